time_entry_buffer: RTL and testbench

Keypad time-entry stage directly upstream of the minutes/seconds down-counter chain of the microwave timer. It collects up to three decimal keypresses as M:SS BCD digits and validates or normalizes the entered value. On START it drives the parallel-load data and an active-low load strobe into the three MOD-10/MOD-6 counters, then holds the count enable until the chain reports zero.

---
 rtl/microwave_timer_pkg.sv | 20 ++
 rtl/bcd_time_normalize.sv | 26 ++
 rtl/time_entry_buffer.sv | 125 ++++++++++++
 tb/tb_time_entry_buffer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/microwave_timer_pkg.sv
// Shared types and constants for the microwave timer keypad/counter slice.
package microwave_timer_pkg;

  localparam int         DIGIT_W     = 4;
  localparam int         MAX_DIGITS  = 3;
  localparam logic [3:0] START_CODE  = 4'hA;
  localparam logic [3:0] CANCEL_CODE = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ARMED = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_time_normalize.sv
// Turns a raw M:SS BCD entry into a legal M:SS value (tens-of-seconds <= 5).
// TIME_ENTRY_NORMALIZE_EN carries excess seconds into minutes; otherwise clamps to :59.
module bcd_time_normalize
  import microwave_timer_pkg::*;
(
  input  logic [3*DIGIT_W-1:0] buf_i,
  output logic [3*DIGIT_W-1:0] time_o
);

  logic [DIGIT_W-1:0] b2, b1, b0;
  assign {b2, b1, b0} = buf_i;

  always_comb begin
    time_o = buf_i;
    if (b1 > 4'd5) begin
`ifdef TIME_ENTRY_NORMALIZE_EN
      // keys only supply 0-9, so b1-6 stays within 0..3
      if (b2 == 4'd9) time_o = 12'h959;
      else            time_o = {b2 + 4'd1, b1 - 4'd6, b0};
`else
      time_o = {b2, 4'd5, 4'd9};
`endif
    end
  end

endmodule

// File: rtl/time_entry_buffer.sv
// Keypad M:SS entry buffer feeding the down-counter chain: collects digits,
// normalizes on START, pulses loadn, holds run until the chain reaches zero.
// Optional feature macro: TIME_ENTRY_NORMALIZE_EN (see bcd_time_normalize).
module time_entry_buffer
  import microwave_timer_pkg::*;
(
  input  logic               clock,
  input  logic               clrn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               timer_zero,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               loadn,
  output logic               run,
  output logic               done,
  output logic [1:0]         digit_cnt
);

  state_e                 state_q, state_d;
  logic [3*DIGIT_W-1:0]   buf_q, buf_d;
  logic [3*DIGIT_W-1:0]   out_q, out_d;
  logic [3*DIGIT_W-1:0]   norm;
  logic [1:0]             cnt_q, cnt_d;
  logic                   loadn_q, loadn_d;
  logic                   run_q, run_d;
  logic                   done_q, done_d;
  logic                   key_dig, key_start, key_cancel;

  bcd_time_normalize u_norm (
    .buf_i  (buf_q),
    .time_o (norm)
  );

  assign key_dig    = key_valid && is_digit(key_code);
  assign key_start  = key_valid && (key_code == START_CODE);
  assign key_cancel = key_valid && (key_code == CANCEL_CODE);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    loadn_d = 1'b1;
    run_d   = run_q;
    done_d  = 1'b0;
    // CANCEL overrides everything, including a same-cycle timer_zero
    if (key_cancel) begin
      state_d = ST_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_dig) begin
            buf_d   = {8'h00, key_code};
            cnt_d   = 2'd1;
            state_d = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (key_dig) begin
            if (cnt_q < 2'(MAX_DIGITS)) begin
              buf_d = {buf_q[2*DIGIT_W-1:0], key_code};
              cnt_d = cnt_q + 2'd1;
            end
          end else if (key_start) begin
            if (buf_q != '0) begin
              out_d   = norm;
              loadn_d = 1'b0;
              state_d = ST_LOAD;
            end else begin
              buf_d   = '0;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
        ST_LOAD: begin
          run_d   = 1'b1;
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (timer_zero) begin
            run_d   = 1'b0;
            done_d  = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      loadn_q <= 1'b1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      loadn_q <= loadn_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign {min_ones, sec_tens, sec_ones} = out_q;
  assign loadn     = loadn_q;
  assign run       = run_q;
  assign done      = done_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_time_entry_buffer.sv
// Directed bench for time_entry_buffer; expected values are hand-computed.
module tb_time_entry_buffer;

  logic       clock = 1'b0;
  logic       clrn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       timer_zero;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       loadn, run, done;
  logic [1:0] digit_cnt;

  int checks   = 0;
  int failures = 0;

  time_entry_buffer dut (
    .clock      (clock),
    .clrn       (clrn),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .timer_zero (timer_zero),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .loadn      (loadn),
    .run        (run),
    .done       (done),
    .digit_cnt  (digit_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive a key for exactly one sampling edge; returns at the following negedge
  task automatic press(input logic [3:0] code);
    @(negedge clock);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clock);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  function automatic logic [11:0] mss();
    return {min_ones, sec_tens, sec_ones};
  endfunction

  logic [11:0] exp99;

  initial begin
`ifdef TIME_ENTRY_NORMALIZE_EN
    exp99 = 12'h139;
`else
    exp99 = 12'h059;
`endif
    clrn = 1'b0; key_valid = 1'b0; key_code = 4'h0; timer_zero = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_data",  mss(), 12'h000);
    chk("rst_loadn", 12'(loadn), 12'd1);
    chk("rst_run",   12'(run), 12'd0);
    chk("rst_done",  12'(done), 12'd0);
    chk("rst_cnt",   12'(digit_cnt), 12'd0);
    clrn = 1'b1;

    // ignored codes in IDLE
    press(4'hA); press(4'hC);
    chk("idle_ignore_cnt",   12'(digit_cnt), 12'd0);
    chk("idle_ignore_loadn", 12'(loadn), 12'd1);

    // 1,3,0,START -> 1:30
    press(4'd1); chk("cnt_after_1", 12'(digit_cnt), 12'd1);
    press(4'd3); press(4'd0);
    chk("cnt_after_130", 12'(digit_cnt), 12'd3);
    chk("loadn_pre_start", 12'(loadn), 12'd1);
    press(4'hA);
    chk("t1_data",  mss(), 12'h130);
    chk("t1_loadn_low", 12'(loadn), 12'd0);
    chk("t1_run_pre", 12'(run), 12'd0);
    @(negedge clock);
    chk("t1_loadn_high", 12'(loadn), 12'd1);
    chk("t1_run", 12'(run), 12'd1);
    // ARMED ignores digits and START
    press(4'd7); press(4'hA);
    chk("armed_ignore_run", 12'(run), 12'd1);
    chk("armed_ignore_loadn", 12'(loadn), 12'd1);
    chk("armed_ignore_data", mss(), 12'h130);
    // countdown reaches zero
    timer_zero = 1'b1;
    @(negedge clock);
    timer_zero = 1'b0;
    chk("tz_done", 12'(done), 12'd1);
    chk("tz_run",  12'(run), 12'd0);
    chk("tz_cnt",  12'(digit_cnt), 12'd0);
    @(negedge clock);
    chk("tz_done_pulse", 12'(done), 12'd0);
    chk("tz_data_hold", mss(), 12'h130);

    // 9,9,START -> build-dependent
    press(4'd9); press(4'd9); press(4'hA);
    chk("t99_data", mss(), exp99);
    chk("t99_loadn", 12'(loadn), 12'd0);
    @(negedge clock);
    chk("t99_run", 12'(run), 12'd1);
    // CANCEL and timer_zero together: CANCEL wins
    key_valid = 1'b1; key_code = 4'hB; timer_zero = 1'b1;
    @(negedge clock);
    key_valid = 1'b0; key_code = 4'h0; timer_zero = 1'b0;
    chk("cxl_done", 12'(done), 12'd0);
    chk("cxl_run",  12'(run), 12'd0);
    chk("cxl_cnt",  12'(digit_cnt), 12'd0);
    chk("cxl_data_hold", mss(), exp99);
    @(negedge clock);
    chk("cxl_done_late", 12'(done), 12'd0);

    // 9,9,9 -> 9:59 in both builds
    press(4'd9); press(4'd9); press(4'd9); press(4'hA);
    chk("t999_data", mss(), 12'h959);
    press(4'hB);
    chk("t999_cxl_run", 12'(run), 12'd0);

    // 1,2,3,4 -> fourth digit ignored
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("t1234_cnt", 12'(digit_cnt), 12'd3);
    press(4'hA);
    chk("t1234_data", mss(), 12'h123);
    press(4'hB);

    // START with empty buffer, then 0,0,START: no load
    press(4'hA);
    chk("empty_loadn", 12'(loadn), 12'd1);
    press(4'd0); press(4'd0);
    chk("zero_cnt", 12'(digit_cnt), 12'd2);
    press(4'hA);
    chk("zero_loadn", 12'(loadn), 12'd1);
    chk("zero_cnt_clr", 12'(digit_cnt), 12'd0);
    @(negedge clock);
    chk("zero_run", 12'(run), 12'd0);
    chk("zero_data_hold", mss(), 12'h123);
    press(4'd2);
    chk("zero_back_idle", 12'(digit_cnt), 12'd1);
    press(4'hB);

    // reset pulsed during LOAD
    press(4'd5); press(4'hA);
    chk("rl_loadn_pre", 12'(loadn), 12'd0);
    #2 clrn = 1'b0;
    #1;
    chk("rl_loadn", 12'(loadn), 12'd1);
    chk("rl_run",   12'(run), 12'd0);
    chk("rl_data",  mss(), 12'h000);
    chk("rl_cnt",   12'(digit_cnt), 12'd0);
    @(negedge clock);
    clrn = 1'b1;
    @(negedge clock);
    chk("rl_run_after", 12'(run), 12'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
